// File: rtl/fetch_redirect_unit.sv
// Fetch PC owner and IF/ID register with single-outstanding imem requests.
// Redirects flush IF/ID and squash any response that belongs to the old path.
module fetch_redirect_unit #(
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int PC_STEP     = 4,
  parameter int RESET_PC    = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stopSignal,
  input  logic                   selectPCMux,
  input  logic [PC_WIDTH-1:0]    branchTarget,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   imem_valid,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  output logic [INSTR_WIDTH-1:0] instrD,
  output logic [PC_WIDTH-1:0]    pcD,
  output logic                   validD,
  output logic [1:0]             fetchState
);

  typedef enum logic [1:0] {
    REQ  = 2'b00,
    WAIT = 2'b01,
    HOLD = 2'b10
  } state_t;

  state_t                 state;
  logic [PC_WIDTH-1:0]    pcF;
  logic                   squash;
  logic [INSTR_WIDTH-1:0] bufInstr;
  logic [PC_WIDTH-1:0]    bufPc;
  logic [PC_WIDTH-1:0]    pcNext;

  assign pcNext     = pcF + PC_WIDTH'(PC_STEP);
  assign imem_req   = (state == REQ) && !selectPCMux && !reset;
  assign imem_addr  = pcF;
  assign fetchState = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= REQ;
      pcF      <= PC_WIDTH'(RESET_PC);
      squash   <= 1'b0;
      bufInstr <= '0;
      bufPc    <= '0;
      instrD   <= '0;
      pcD      <= '0;
      validD   <= 1'b0;
    end else if (selectPCMux) begin
      pcF    <= branchTarget;
      validD <= 1'b0;
      case (state)
        WAIT: begin
          // A response landing now is dropped; otherwise mark it for squash.
          if (imem_valid) begin
            squash <= 1'b0;
            state  <= REQ;
          end else begin
            squash <= 1'b1;
          end
        end
        default: state <= REQ;
      endcase
    end else begin
      case (state)
        REQ: begin
          state <= WAIT;
          if (!stopSignal) validD <= 1'b0;
        end
        WAIT: begin
          if (imem_valid && squash) begin
            squash <= 1'b0;
            state  <= REQ;
            if (!stopSignal) validD <= 1'b0;
          end else if (imem_valid && !stopSignal) begin
            instrD <= imem_rdata;
            pcD    <= pcF;
            validD <= 1'b1;
            pcF    <= pcNext;
            state  <= REQ;
          end else if (imem_valid) begin
            bufInstr <= imem_rdata;
            bufPc    <= pcF;
            state    <= HOLD;
          end else if (!stopSignal) begin
            validD <= 1'b0;
          end
        end
        HOLD: begin
          if (!stopSignal) begin
            instrD <= bufInstr;
            pcD    <= bufPc;
            validD <= 1'b1;
            pcF    <= pcNext;
            state  <= REQ;
          end
        end
        default: begin
          state <= REQ;
          if (!stopSignal) validD <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed bench for fetch_redirect_unit: sequential fetch, stall,
// redirect, combined redirect/stall, wrap-around and async reset.
module tb_fetch_redirect_unit;

  logic        clk;
  logic        reset;
  logic        stopSignal;
  logic        selectPCMux;
  logic [31:0] branchTarget;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] instrD;
  logic [31:0] pcD;
  logic        validD;
  logic [1:0]  fetchState;

  int checks = 0;
  int errors = 0;

  fetch_redirect_unit dut (
    .clk(clk),
    .reset(reset),
    .stopSignal(stopSignal),
    .selectPCMux(selectPCMux),
    .branchTarget(branchTarget),
    .imem_rdata(imem_rdata),
    .imem_valid(imem_valid),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .instrD(instrD),
    .pcD(pcD),
    .validD(validD),
    .fetchState(fetchState)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instOf(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic serve(input logic [31:0] d);
    imem_valid = 1'b1;
    imem_rdata = d;
    step();
    imem_valid = 1'b0;
    imem_rdata = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; stopSignal = 0; selectPCMux = 0;
    branchTarget = '0; imem_rdata = '0; imem_valid = 0;
    #11;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", imem_req); end
    checks++; if (validD !== 1'b0) begin errors++; $display("FAIL rst_validD: got %b want 0", validD); end
    checks++; if (instrD !== 32'h0) begin errors++; $display("FAIL rst_instrD: got %h want 0", instrD); end
    checks++; if (pcD !== 32'h0) begin errors++; $display("FAIL rst_pcD: got %h want 0", pcD); end
    checks++; if (fetchState !== 2'b00) begin errors++; $display("FAIL rst_state: got %b want 00", fetchState); end
    #1;
    reset = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rst_req_after: got %b want 1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
  endtask

  task automatic test_sequential();
    step();
    checks++; if (fetchState !== 2'b01) begin errors++; $display("FAIL seq_wait: got %b want 01", fetchState); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL seq_noreq: got %b want 0", imem_req); end
    for (int i = 0; i < 3; i++) begin
      logic [31:0] a;
      a = 32'(i * 4);
      if (i != 0) begin
        step();
        checks++; if (validD !== 1'b0) begin errors++; $display("FAIL seq_bubble%0d: got %b want 0", i, validD); end
      end
      serve(instOf(a));
      checks++; if (pcD !== a) begin errors++; $display("FAIL seq_pcD%0d: got %h want %h", i, pcD, a); end
      checks++; if (instrD !== instOf(a)) begin errors++; $display("FAIL seq_instrD%0d: got %h want %h", i, instrD, instOf(a)); end
      checks++; if (validD !== 1'b1) begin errors++; $display("FAIL seq_validD%0d: got %b want 1", i, validD); end
      checks++; if (imem_addr !== a + 4) begin errors++; $display("FAIL seq_addr%0d: got %h want %h", i, imem_addr, a + 4); end
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL seq_req%0d: got %b want 1", i, imem_req); end
    end
  endtask

  task automatic test_stall();
    stopSignal = 1'b1;
    step();
    checks++; if (validD !== 1'b1) begin errors++; $display("FAIL stall_keepv: got %b want 1", validD); end
    serve(instOf(32'hC));
    checks++; if (fetchState !== 2'b10) begin errors++; $display("FAIL stall_hold: got %b want 10", fetchState); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_noreq: got %b want 0", imem_req); end
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin imem_valid = 1'b1; imem_rdata = 32'hDEAD_BEEF; end
      step();
      imem_valid = 1'b0;
      checks++; if (fetchState !== 2'b10) begin errors++; $display("FAIL stall_state%0d: got %b want 10", i, fetchState); end
      checks++; if (pcD !== 32'h8 || instrD !== instOf(32'h8)) begin errors++; $display("FAIL stall_ifid%0d: got %h/%h want 8/%h", i, pcD, instrD, instOf(32'h8)); end
    end
    stopSignal = 1'b0;
    step();
    checks++; if (pcD !== 32'hC) begin errors++; $display("FAIL stall_rel_pcD: got %h want c", pcD); end
    checks++; if (instrD !== instOf(32'hC)) begin errors++; $display("FAIL stall_rel_instr: got %h want %h", instrD, instOf(32'hC)); end
    checks++; if (validD !== 1'b1) begin errors++; $display("FAIL stall_rel_v: got %b want 1", validD); end
    checks++; if (imem_addr !== 32'h10 || imem_req !== 1'b1) begin errors++; $display("FAIL stall_next: got %h/%b want 10/1", imem_addr, imem_req); end
  endtask

  task automatic test_redirect();
    step();
    selectPCMux = 1'b1; branchTarget = 32'h40;
    step();
    selectPCMux = 1'b0;
    checks++; if (fetchState !== 2'b01) begin errors++; $display("FAIL rd_staywait: got %b want 01", fetchState); end
    checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL rd_addr: got %h want 40", imem_addr); end
    serve(instOf(32'h10));
    checks++; if (validD !== 1'b0) begin errors++; $display("FAIL rd_squash_v: got %b want 0", validD); end
    checks++; if (pcD !== 32'hC) begin errors++; $display("FAIL rd_squash_pc: got %h want c", pcD); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin errors++; $display("FAIL rd_newreq: got %b/%h want 1/40", imem_req, imem_addr); end
    step();
    serve(instOf(32'h40));
    checks++; if (pcD !== 32'h40 || instrD !== instOf(32'h40) || validD !== 1'b1) begin errors++; $display("FAIL rd_load: got %h/%h/%b want 40/%h/1", pcD, instrD, validD, instOf(32'h40)); end
    selectPCMux = 1'b1; branchTarget = 32'h80;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rd_req_block: got %b want 0", imem_req); end
    step();
    selectPCMux = 1'b0;
    #1;
    checks++; if (fetchState !== 2'b00 || validD !== 1'b0 || imem_addr !== 32'h80) begin errors++; $display("FAIL rd_inreq: got %b/%b/%h want 00/0/80", fetchState, validD, imem_addr); end
    step();
    selectPCMux = 1'b1; branchTarget = 32'h100;
    imem_valid = 1'b1; imem_rdata = instOf(32'h80);
    step();
    selectPCMux = 1'b0; imem_valid = 1'b0;
    checks++; if (fetchState !== 2'b00 || validD !== 1'b0 || imem_addr !== 32'h100) begin errors++; $display("FAIL rd_samecyc: got %b/%b/%h want 00/0/100", fetchState, validD, imem_addr); end
    step();
    serve(instOf(32'h100));
    checks++; if (pcD !== 32'h100 || validD !== 1'b1) begin errors++; $display("FAIL rd_nosquash: got %h/%b want 100/1", pcD, validD); end
  endtask

  task automatic test_redirect_stall();
    stopSignal = 1'b1;
    step();
    serve(instOf(32'h104));
    checks++; if (fetchState !== 2'b10) begin errors++; $display("FAIL rs_hold: got %b want 10", fetchState); end
    selectPCMux = 1'b1; branchTarget = 32'h200;
    step();
    checks++; if (fetchState !== 2'b00 || validD !== 1'b0 || imem_addr !== 32'h200 || imem_req !== 1'b0) begin errors++; $display("FAIL rs_redir: got %b/%b/%h/%b want 00/0/200/0", fetchState, validD, imem_addr, imem_req); end
    selectPCMux = 1'b0; stopSignal = 1'b0;
    step();
    serve(instOf(32'h200));
    checks++; if (pcD !== 32'h200 || instrD !== instOf(32'h200)) begin errors++; $display("FAIL rs_load: got %h/%h want 200/%h", pcD, instrD, instOf(32'h200)); end
  endtask

  task automatic test_wrap();
    selectPCMux = 1'b1; branchTarget = 32'hFFFF_FFFC;
    step();
    selectPCMux = 1'b0;
    #1;
    checks++; if (imem_addr !== 32'hFFFF_FFFC || imem_req !== 1'b1) begin errors++; $display("FAIL wrap_req: got %h/%b want fffffffc/1", imem_addr, imem_req); end
    step();
    serve(instOf(32'hFFFF_FFFC));
    checks++; if (pcD !== 32'hFFFF_FFFC || validD !== 1'b1) begin errors++; $display("FAIL wrap_load: got %h/%b want fffffffc/1", pcD, validD); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h want 0", imem_addr); end
  endtask

  task automatic test_async_reset();
    selectPCMux = 1'b1; branchTarget = 32'h300;
    step();
    selectPCMux = 1'b0;
    step();
    checks++; if (fetchState !== 2'b01 || imem_addr !== 32'h300) begin errors++; $display("FAIL ar_setup: got %b/%h want 01/300", fetchState, imem_addr); end
    #3;
    reset = 1'b1;
    #1;
    checks++; if (pcD !== 32'h0 || instrD !== 32'h0 || validD !== 1'b0) begin errors++; $display("FAIL ar_ifid: got %h/%h/%b want 0/0/0", pcD, instrD, validD); end
    checks++; if (fetchState !== 2'b00 || imem_req !== 1'b0 || imem_addr !== 32'h0) begin errors++; $display("FAIL ar_state: got %b/%b/%h want 00/0/0", fetchState, imem_req, imem_addr); end
    #2;
    reset = 1'b0;
    imem_valid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL ar_req: got %b/%h want 1/0", imem_req, imem_addr); end
    step();
    imem_valid = 1'b0;
    checks++; if (validD !== 1'b0 || fetchState !== 2'b01) begin errors++; $display("FAIL ar_late: got %b/%b want 0/01", validD, fetchState); end
    serve(instOf(32'h0));
    checks++; if (instrD !== instOf(32'h0) || pcD !== 32'h0 || validD !== 1'b1) begin errors++; $display("FAIL ar_first: got %h/%h/%b want %h/0/1", instrD, pcD, validD, instOf(32'h0)); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_redirect_unit.md
Name: fetch_redirect_unit

Overview:
- Fetch-side consumer of the hazard unit's `stopSignal` and `selectPCMux` outputs.
- Owns the fetch PC and issues single-outstanding instruction-memory requests.
- Holds the IF/ID pipeline register; stalls it on `stopSignal`, and on `selectPCMux` flushes it and redirects fetch to the branch target.
- Squashes any in-flight memory response belonging to the wrong path.

Parameters:
- PC_WIDTH, 32, width of all PC/address signals.
- INSTR_WIDTH, 32, instruction word width.
- PC_STEP, 4, sequential PC increment.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stopSignal  in  1  stall request from hazard unit; hold IF/ID and PC.
- selectPCMux  in  1  redirect request from hazard unit; take `branchTarget`, flush IF/ID.
- branchTarget  in  PC_WIDTH  redirect PC, sampled when `selectPCMux`=1.
- imem_rdata  in  INSTR_WIDTH  instruction returned by memory.
- imem_valid  in  1  `imem_rdata` valid this cycle; at least 1 cycle after the request.
- imem_req  out  1  one-cycle request pulse.
- imem_addr  out  PC_WIDTH  request address (= `pcF`).
- instrD  out  INSTR_WIDTH  IF/ID instruction.
- pcD  out  PC_WIDTH  IF/ID PC.
- validD  out  1  IF/ID holds a real instruction.
- fetchState  out  2  current FSM state (debug).

Behaviour:
- **Reset (async, immediate):**
  - `pcF`=RESET_PC, state=REQ, squash=0, buffer empty.
  - `instrD`=0, `pcD`=0, `validD`=0.
  - `imem_req` forced 0 while reset=1.
- **State encoding:** REQ=2'b00, WAIT=2'b01, HOLD=2'b10; 2'b11 unused and goes to REQ.
- **`imem_req`/`imem_addr`:** `imem_req` = (state==REQ) && !selectPCMux && !reset. `imem_addr` = `pcF` at all times.
- **Priority per cycle:** reset > selectPCMux > stopSignal > normal flow.
- **REQ:**
  - Request issued.
  - Next state WAIT, unless `selectPCMux`=1: then no request, stay REQ, `pcF`<=`branchTarget`.
- **WAIT:**
  - `imem_valid`=0: stay WAIT.
  - `imem_valid`=1 with squash=1: discard data, clear squash, go REQ. `pcF` already holds the target.
  - `imem_valid`=1, squash=0, `stopSignal`=0: IF/ID <= {`imem_rdata`, `pcF`, 1}; `pcF`<=`pcF`+PC_STEP; go REQ.
  - `imem_valid`=1, squash=0, `stopSignal`=1: capture `imem_rdata` and `pcF` into buffer; go HOLD.
- **HOLD:**
  - `stopSignal`=1: stay; IF/ID and buffer unchanged.
  - `stopSignal`=0: IF/ID <= buffer, `validD`=1; `pcF`+=PC_STEP; go REQ.
- **Redirect (`selectPCMux`=1), any state:**
  - `pcF`<=`branchTarget`; `validD`<=0 (`instrD`/`pcD` may keep old values).
  - WAIT without `imem_valid`: set squash, stay WAIT.
  - WAIT with `imem_valid` the same cycle: drop data, go REQ, squash stays 0.
  - HOLD: discard buffer, go REQ.
  - Redirect overrides a simultaneous `stopSignal`.
- **Bubble insertion:** when `stopSignal`=0, no redirect, and no instruction is loaded this cycle, `validD`<=0.
- **Stall:** `stopSignal`=1 without redirect leaves `instrD`/`pcD`/`validD` unchanged.
- **PC width:** addition is modulo 2^PC_WIDTH; 32'hFFFFFFFC+4 wraps to 0.
- **Latency:** instruction appears in IF/ID on the edge after `imem_valid` (no stall). Steady-state throughput with 1-cycle memory is one instruction per 2 cycles.
- **Reset mid-operation:**
  - Outstanding request is abandoned.
  - A late `imem_valid` arriving in REQ state is ignored.
  - `imem_valid` in REQ or HOLD is always ignored.

Test Plan:
- **Reset then sequential fetch:** reset 10 time units, memory returns 1 cycle after request -> requests at 0x0, 0x4, 0x8. IF/ID shows (0x0,I0), (0x4,I1), (0x8,I2) with `validD`=1. `validD`=0 in the cycles between loads.
- **Stall during WAIT:** `stopSignal`=1 when I1 arrives -> state HOLD, IF/ID keeps (0x0,I0) for 5 cycles. On release, IF/ID=(0x4,I1) next edge, next request at 0x8.
- **Redirect with outstanding request:**
  - Setup: `selectPCMux`=1, `branchTarget`=0x40 in the cycle after request 0x8 issues.
  - Response for 0x8 is discarded; `validD`=0.
  - Next request is at 0x40; IF/ID later shows (0x40,Ix).
- **Redirect and stall simultaneous** (OpCode 4'b0011 branch, zeroFlag=1 case): `stopSignal`=1 and `selectPCMux`=1 in HOLD -> buffer dropped, `validD`=0, `pcF`=`branchTarget`, state REQ.
- **Wrap-around:** `branchTarget`=32'hFFFFFFFC -> fetch 0xFFFFFFFC, then request at 0x00000000.
- **Asynchronous reset in WAIT:** assert reset mid-cycle -> outputs clear immediately without a clock edge. A subsequent `imem_valid` is ignored; first post-reset request is at RESET_PC.
